// File: rtl/fifo_uart_tx_if.sv
// Bundle of signals between the byte FIFO, the transmit control and the
// serial line for fifo_uart_tx.
//
// Pop handshake: buf_empty is the FIFO's "data available" flag (active low)
// and rd_en is the pop strobe. rd_en is only raised when buf_empty was
// sampled low, is exactly one clock wide, and the popped byte is valid on
// buf_out from the clock edge after the one that sampled rd_en. There is
// no back-pressure from the FIFO side.
interface fifo_uart_tx_if;
    logic       tx_en;      // permission to start a new frame
    logic       buf_empty;  // FIFO empty flag
    logic [7:0] buf_out;    // FIFO registered read data
    logic       rd_en;      // FIFO pop strobe
    logic       tx;         // serial line, idle high
    logic       busy;       // transmitter not idle
    logic       tx_done;    // one-cycle end-of-frame pulse
    logic [2:0] state_dbg;  // current FSM state encoding

    // Transmitter side
    modport master (
        input  tx_en, buf_empty, buf_out,
        output rd_en, tx, busy, tx_done, state_dbg
    );

    // FIFO / environment side
    modport slave (
        output tx_en, buf_empty, buf_out,
        input  rd_en, tx, busy, tx_done, state_dbg
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a registered-read byte FIFO. Pops one byte,
// waits for it to appear on buf_out, then shifts it out LSB first as a
// start bit, 8 data bits, optional even parity and 1 or 2 stop bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t           state,      state_d;
    logic [CNT_W-1:0] cnt,        cnt_d;
    logic [2:0]       bit_idx,    bit_idx_d;
    logic             stop_cnt,   stop_cnt_d;
    logic [7:0]       shift_reg,  shift_d;
    logic             parity_bit, parity_d;
    logic             tx_q,       tx_d;
    logic             rd_en_q,    rd_en_d;
    logic             tx_done_q,  tx_done_d;

    logic             bit_last;
    logic [2:0]       next_idx;

    assign bit_last = (cnt == CNT_LAST);
    assign next_idx = bit_idx + 3'd1;

    // Register all state and the registered outputs (tx, rd_en, tx_done).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
            rd_en_q    <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            stop_cnt   <= stop_cnt_d;
            shift_reg  <= shift_d;
            parity_bit <= parity_d;
            tx_q       <= tx_d;
            rd_en_q    <= rd_en_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Next-state and next-output logic. tx_d always carries the level of the
    // bit that starts at the coming edge, so tx changes exactly on bit
    // boundaries without any combinational path to the pin.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        shift_d    = shift_reg;
        parity_d   = parity_bit;
        tx_d       = tx_q;
        rd_en_d    = 1'b0;
        tx_done_d  = 1'b0;

        case (state)
            IDLE: begin
                tx_d       = 1'b1;
                cnt_d      = '0;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
                // tx_en and buf_empty only matter here, so a frame in
                // flight is never affected by either of them.
                if (bus.tx_en && !bus.buf_empty) begin
                    rd_en_d = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                // FIFO samples the pop strobe on this edge; data arrives next.
                state_d = LOAD;
            end

            LOAD: begin
                shift_d  = bus.buf_out;
                parity_d = ^bus.buf_out;
                cnt_d    = '0;
                tx_d     = 1'b0;
                state_d  = START;
            end

            START: begin
                if (bit_last) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_reg[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_last) begin
                    cnt_d = '0;
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_bit;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_idx_d = next_idx;
                        tx_d      = shift_reg[next_idx];
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            PARITY: begin
                if (bit_last) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (bit_last) begin
                    cnt_d = '0;
                    // With two stop bits the first boundary only flips the
                    // stop counter; the frame ends on the second one.
                    if ((STOP_BITS == 2) && !stop_cnt) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        tx_done_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx        = tx_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;

endmodule
